vga_pixel_feeder: RTL and testbench

//  AXI4-Lite slave that buffers CPU-written RGB565 pixels and streams them to the VGA timing stage.

---
 rtl/vga_feeder_pkg.sv | 24 ++
 rtl/vga_feeder_fifo.sv | 57 +++++
 rtl/vga_pixel_feeder.sv | 179 +++++++++++++++++
 tb/tb_vga_pixel_feeder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_feeder_pkg.sv
// +--------------------------------------------------------------------+
// | vga_feeder_pkg : register map, response codes and pixel format    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vga_feeder_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_UFLOW  = 4'hC;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int PIX_W   = 16;
  localparam int RED_W   = 5;
  localparam int GREEN_W = 6;
  localparam int BLUE_W  = 5;

endpackage

`default_nettype wire

// File: rtl/vga_feeder_fifo.sv
// +--------------------------------------------------------------------+
// | vga_feeder_fifo : synchronous word FIFO with flush and level      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_feeder_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Extra MSB on each pointer distinguishes full from empty after wrap.
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign level     = r_wr_ptr - r_rd_ptr;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_ok = push & ~full;
  assign w_pop_ok  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push_ok && !flush) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_pixel_feeder.sv
// +--------------------------------------------------------------------+
// | vga_pixel_feeder : AXI4-Lite to RGB565 pixel stream feeder         |
// | Optional underflow counter: VGA_FEEDER_UFLOW_CNT_EN. Rev 1.0       |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_pixel_feeder
  import vga_feeder_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_FIFO_DEPTH       = 16
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [PIX_W-1:0]              pix_data,
  output logic                          pix_valid,
  input  logic                          pix_ready
);

  localparam int FIFO_AW = $clog2(C_FIFO_DEPTH);

  logic                          r_awready, r_bvalid, r_arready, r_rvalid;
  logic [1:0]                    r_bresp;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                          r_enable, r_overflow;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_word;
  logic                          r_loaded, r_phase;

  logic [3:0]                    w_aw_off, w_ar_off;
  logic                          w_wr, w_rd, w_flush, w_push_req, w_push, w_load, w_pix_hs;
  logic                          w_full, w_empty;
  logic [FIFO_AW:0]              w_level;
  logic [8:0]                    w_level_ext;
  logic [7:0]                    w_level8;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_fifo_dout, w_uflow, w_rd_mux;
  logic                          w_unused;

  assign w_aw_off   = {S_AXI_AWADDR[3:2], 2'b00};
  assign w_ar_off   = {S_AXI_ARADDR[3:2], 2'b00};
  assign w_wr       = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd       = r_arready & S_AXI_ARVALID;
  assign w_flush    = w_wr & (w_aw_off == REG_CTRL) & S_AXI_WDATA[1];
  assign w_push_req = w_wr & (w_aw_off == REG_DATA);
  assign w_push     = w_push_req & ~w_full & ~w_flush;
  assign w_pix_hs   = pix_valid & pix_ready;
  // Refill when idle, or as the upper half is consumed, so a non-empty FIFO streams bubble-free.
  assign w_load     = r_enable & ~w_empty & ~w_flush & (~r_loaded | (w_pix_hs & r_phase));

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign pix_valid     = r_enable & r_loaded;
  assign pix_data      = r_phase ? r_word[2*PIX_W-1:PIX_W] : r_word[PIX_W-1:0];

  assign w_unused = &{1'b0, S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_AWADDR[1:0],
                      S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:4], S_AXI_ARADDR[1:0], S_AXI_WSTRB};

  vga_feeder_fifo #(
    .WIDTH (C_S_AXI_DATA_WIDTH),
    .DEPTH (C_FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .flush (w_flush),
    .push  (w_push),
    .din   (S_AXI_WDATA),
    .pop   (w_load),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // Level field is 8 bits wide; a 256-deep FIFO saturates it when full.
  assign w_level_ext = 9'(w_level);
  assign w_level8    = w_level_ext[8] ? 8'hFF : w_level_ext[7:0];

`ifdef VGA_FEEDER_UFLOW_CNT_EN
  logic [15:0] r_uflow;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)                                             r_uflow <= '0;
    else if (w_flush)                                               r_uflow <= '0;
    else if (r_enable && pix_ready && !pix_valid && r_uflow != 16'hFFFF) r_uflow <= r_uflow + 16'd1;
  end

  assign w_uflow = C_S_AXI_DATA_WIDTH'(r_uflow);
`else
  assign w_uflow = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (w_ar_off)
      REG_STATUS: w_rd_mux = {16'h0, w_level8, 5'h0, r_overflow, w_full, w_empty};
      REG_CTRL:   w_rd_mux = {{(C_S_AXI_DATA_WIDTH-1){1'b0}}, r_enable};
      REG_UFLOW:  w_rd_mux = w_uflow;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready  <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_enable   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_awready <= ~r_awready & S_AXI_AWVALID & S_AXI_WVALID & ~r_bvalid;
      if (w_wr) begin
        r_bvalid <= 1'b1;
        r_bresp  <= (w_push_req && w_full && !w_flush) ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      if (w_wr && w_aw_off == REG_CTRL) r_enable <= S_AXI_WDATA[0];
      if (w_flush)                      r_overflow <= 1'b0;
      else if (w_push_req && w_full)    r_overflow <= 1'b1;

      r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_mux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_word   <= '0;
      r_loaded <= 1'b0;
      r_phase  <= 1'b0;
    end else if (w_flush) begin
      r_word   <= '0;
      r_loaded <= 1'b0;
      r_phase  <= 1'b0;
    end else if (w_load) begin
      r_word   <= w_fifo_dout;
      r_loaded <= 1'b1;
      r_phase  <= 1'b0;
    end else if (w_pix_hs) begin
      r_loaded <= ~r_phase;
      r_phase  <= ~r_phase;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_feeder.sv
// +--------------------------------------------------------------------+
// | tb_vga_pixel_feeder : directed bench for vga_pixel_feeder          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vga_pixel_feeder;
  import vga_feeder_pkg::*;

`ifdef VGA_FEEDER_UFLOW_CNT_EN
  localparam logic [31:0] EXP_UFLOW = 32'd10;
`else
  localparam logic [31:0] EXP_UFLOW = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [15:0] pix_data;
  logic        pix_valid, pix_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_pixel_feeder #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_FIFO_DEPTH       (16)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           output logic [1:0] resp, output logic pv_after);
    bit ok = 1'b0;
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      ok = awready && wready;
    end
    check("aw_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    pv_after = pix_valid;
    check("bvalid", 32'(bvalid), 32'd1);
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    bit ok = 1'b0;
    araddr = a; arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      ok = arready;
    end
    check("ar_handshake", 32'(ok), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid", {30'h0, rresp}, {31'h0, !rvalid});
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic        pv;
    logic [31:0] rd;
    int          idx;
    logic        held;
    logic [15:0] hv;

    vecs[0] = '{1'b0, 32'(REG_STATUS), 32'h0, 32'h0000_0001};
    vecs[1] = '{1'b0, 32'(REG_CTRL),   32'h0, 32'h0000_0001};
    vecs[2] = '{1'b1, 32'(REG_CTRL),   32'h0, 32'(RESP_OKAY)};
    for (int i = 0; i < 16; i++)
      vecs[3+i] = '{1'b1, 32'(REG_DATA), {16'(2*i+1), 16'(2*i)}, 32'(RESP_OKAY)};
    vecs[19] = '{1'b1, 32'(REG_DATA),   32'hDEAD_BEEF, 32'(RESP_SLVERR)};
    vecs[20] = '{1'b0, 32'(REG_STATUS), 32'h0, 32'h0000_1006};
    vecs[21] = '{1'b0, 32'(REG_CTRL),   32'h0, 32'h0000_0000};

    rst_n = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",  {29'h0, awready, wready, arready}, 32'h0);
    check("rst_valid",  {29'h0, bvalid, rvalid, pix_valid}, 32'h0);
    check("rst_resp",   {28'h0, bresp, rresp}, 32'h0);
    check("rst_rdata",  rdata, 32'h0);
    check("rst_pix",    32'(pix_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle status after reset
    axi_read(32'(REG_STATUS), rd);
    check("status_reset", rd, 32'h0000_0001);
    check("pix_valid_reset", 32'(pix_valid), 32'h0);

    // Single word unpacked low half first, two-cycle latency
    axi_write(32'(REG_CTRL), 32'h1, resp, pv);
    pix_ready = 1'b1;
    axi_write(32'(REG_DATA), 32'hF800_07E0, resp, pv);
    check("lat_not_early", 32'(pv), 32'h0);
    check("pix0_valid", 32'(pix_valid), 32'h1);
    check("pix0_data",  32'(pix_data),  32'h07E0);
    @(posedge clk); #1;
    check("pix1_valid", 32'(pix_valid), 32'h1);
    check("pix1_data",  32'(pix_data),  32'hF800);
    @(posedge clk); #1;
    check("pix_drained", 32'(pix_valid), 32'h0);
    pix_ready = 1'b0;

    // Register table: fill to full with output disabled, then overflow
    for (int i = 0; i < 22; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, resp, pv);
        check($sformatf("vec%0d_bresp", i), 32'(resp), vecs[i].exp);
      end else begin
        axi_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
      check($sformatf("vec%0d_nopix", i), 32'(pix_valid), 32'h0);
    end

    // Drain 32 pixels with back-pressure
    axi_write(32'(REG_CTRL), 32'h1, resp, pv);
    idx  = 0;
    held = 1'b0;
    hv   = '0;
    for (int cyc = 0; cyc < 300 && idx < 32; cyc++) begin
      @(posedge clk); #1;
      if (held) check("hold_stable", 32'(pix_data), 32'(hv));
      pix_ready = cyc[0];
      if (pix_valid && pix_ready) begin
        check($sformatf("order%0d", idx), 32'(pix_data), 32'(idx));
        idx++;
      end
      held = pix_valid && !pix_ready;
      hv   = pix_data;
    end
    @(posedge clk); #1;
    pix_ready = 1'b0;
    check("drain_count", 32'(idx), 32'd32);
    check("drain_valid", 32'(pix_valid), 32'h0);
    axi_read(32'(REG_STATUS), rd);
    check("status_drained", rd, 32'h0000_0005);

    // Flush with words queued
    for (int i = 0; i < 4; i++) axi_write(32'(REG_DATA), 32'hA5A5_0100 + 32'(i), resp, pv);
    @(posedge clk); #1;
    check("preflush_valid", 32'(pix_valid), 32'h1);
    check("preflush_data",  32'(pix_data),  32'h0100);
    axi_write(32'(REG_CTRL), 32'h3, resp, pv);
    check("flush_next_cycle", 32'(pv), 32'h0);
    check("flush_valid", 32'(pix_valid), 32'h0);
    axi_read(32'(REG_STATUS), rd);
    check("status_flushed", rd, 32'h0000_0001);
    axi_read(32'(REG_CTRL), rd);
    check("ctrl_after_flush", rd, 32'h0000_0001);

    // Underflow counting on an empty, enabled stream
    axi_read(32'(REG_UFLOW), rd);
    check("uflow_cleared", rd, 32'h0);
    pix_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    pix_ready = 1'b0;
    axi_read(32'(REG_UFLOW), rd);
    check("uflow_count", rd, EXP_UFLOW);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
